ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Parametrised seven-segment multiplexer for the Nexys 4 eight-digit display, replacing hand-written four-digit scan logic in top-level wrappers. It time-multiplexes up to eight hex digits with per-digit blank, dot-point and blink control, and inserts an anti-ghosting guard interval at each digit switch. Digit values are captured into shadow registers once per frame, so the displayed frame never mixes old and new values. The block sits between core status signals (row, column, values) and the An/Ca–Cg/Dp pins.

## Interface
- NUM_DIGITS, 8, active digits (1..8); anodes NUM_DIGITS..7 held off
- SCAN_DIV, 262144, board_clk cycles per digit slot (≥ GUARD+2)
- GUARD, 64, cycles at slot start with all anodes off (0 disables; < SCAN_DIV)
- BLINK_FRAMES, 32, frames per blink half-period (≥ 1)
- board_clk  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high
- digits  in  4*NUM_DIGITS  hex value per digit; digit i = digits[4i+3:4i]; digit 0 = rightmost (An0)
- dp_on  in  NUM_DIGITS  1 = light dot point of digit i
- blank  in  NUM_DIGITS  1 = digit i fully dark
- blink  in  NUM_DIGITS  1 = digit i dark during blink-off phase
- an  out  8  active-low anodes {An7..An0}
- seg  out  7  active-low cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg}
- dp  out  1  active-low dot-point cathode
- frame_tick  out  1  one-cycle pulse at each frame start (shadow capture)

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps; digit index idx advances when pcnt = SCAN_DIV-1, wrapping NUM_DIGITS-1 → 0.
- Frame boundary: pcnt = SCAN_DIV-1 and idx = NUM_DIGITS-1. On that cycle digits/dp_on/blank/blink are copied into shadow registers, and frame_tick is asserted the following cycle (coincident with idx = 0, pcnt = 0).
- Frame counter fcnt counts frames 0..BLINK_FRAMES-1; on wrap, blink phase bph toggles. bph = 1 is the blink-off phase.
- Digit dark = shadow blank[idx] OR (shadow blink[idx] AND bph) OR (pcnt < GUARD).
- Outputs (registered): an = all ones except bit idx = 0 when not dark; seg = hex decode of shadow digit[idx], or 7'h7F when dark; dp = ~dp_on[idx], or 1 when dark.
- Hex decode (abcdefg, active low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Anodes for positions ≥ NUM_DIGITS are constant 1 in every state.
- NUM_DIGITS = 1: idx stays 0; every slot end is a frame boundary.

## Timing
- Reset (async): pcnt=0, idx=0, fcnt=0, bph=0, shadows=0, an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- After Reset release, the first capture occurs at the first frame boundary; until then the shadows are 0 (blank=0), so digit 0 shows "0" once pcnt ≥ GUARD.
- Output latency: an/seg/dp reflect (idx, pcnt, shadows, bph) with a delay of exactly 1 cycle.
- Input changes outside the capture cycle have no visible effect until the next frame boundary; worst-case latency is one frame = NUM_DIGITS*SCAN_DIV cycles, plus 1.
- Frame period is NUM_DIGITS*SCAN_DIV cycles; blink period is 2*BLINK_FRAMES frames.
- Reset asserted mid-frame forces all outputs to their reset values within the same cycle (async); the scan restarts from idx 0.

## Test plan
- Params NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2; digits=16'h1A3F, no blank/blink/dp -> after the first frame_tick, each 8-cycle slot shows an=8'hFF for 2 cycles, then an=8'hFE with seg=0111000 (F), then 8'hFD with 0000110 (3), 8'hFB with 0001000 (A), 8'hF7 with 1001111 (1); frame_tick period is 32 cycles.
- Change digits to 16'h0000 mid-frame -> the remainder of the frame still shows 1A3F; the next frame shows all zeros (seg=0000001).
- blank=4'b0100, dp_on=4'b0001 -> digit 2 slot keeps an=8'hFF and seg=7'h7F; in digit 0 slot dp=0; in all other slots dp=1.
- blink=4'b0010 -> digit 1 lit for 2 frames, dark for 2 frames, repeating every 128 cycles; the other digits are unaffected.
- Assert Reset mid-slot on digit 3 -> an=8'hFF, seg=7'h7F, dp=1 immediately; after release the scan resumes at digit 0 with zero shadows.
- NUM_DIGITS=8, SCAN_DIV=4, GUARD=0 -> anodes walk FE, FD, ... 7F, then wrap; an[7:NUM_DIGITS] never low for NUM_DIGITS=3 rerun.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// Eight-digit seven-segment scan multiplexer with per-frame shadow capture,
// per-digit blank/dot/blink control and an anti-ghosting guard at each digit switch.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 262144,
    parameter int GUARD        = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_on,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink,
    output logic [7:0]              an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_V  = PW'(GUARD);
    localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [FW-1:0]           fcnt_q, fcnt_d;
    logic                    bph_q, bph_d;
    logic [4*NUM_DIGITS-1:0] dig_q;
    logic [NUM_DIGITS-1:0]   dpon_q, blank_q, blink_q;
    logic [7:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    tick_q;

    logic       pcnt_last, frame_end, dark, guard;
    logic [3:0] cur_dig;
    logic       cur_dp, cur_blank, cur_blink;

    always_comb begin
        pcnt_last = (pcnt_q == PC_LAST);
        frame_end = pcnt_last && (idx_q == IDX_LAST);
        pcnt_d    = pcnt_last ? '0 : pcnt_q + 1'b1;
        idx_d     = idx_q;
        if (pcnt_last)
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        fcnt_d = fcnt_q;
        bph_d  = bph_q;
        if (frame_end) begin
            fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;
            if (fcnt_q == FC_LAST)
                bph_d = ~bph_q;
        end

        // Pick the current digit's shadow fields without an oversized index select.
        cur_dig   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_dig   = dig_q[4*i +: 4];
                cur_dp    = dpon_q[i];
                cur_blank = blank_q[i];
                cur_blink = blink_q[i];
            end
        end

        guard = (GUARD != 0) && (pcnt_q < GUARD_V);
        dark  = cur_blank | (cur_blink & bph_q) | guard;
        an_d  = 8'hFF;
        if (!dark)
            an_d[idx_q] = 1'b0;
        seg_d = dark ? 7'h7F : hex7(cur_dig);
        dp_d  = dark | ~cur_dp;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            pcnt_q  <= '0;
            idx_q   <= 3'd0;
            fcnt_q  <= '0;
            bph_q   <= 1'b0;
            dig_q   <= '0;
            dpon_q  <= '0;
            blank_q <= '0;
            blink_q <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            fcnt_q <= fcnt_d;
            bph_q  <= bph_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= frame_end;
            if (frame_end) begin
                dig_q   <= digits;
                dpon_q  <= dp_on;
                blank_q <= blank;
                blink_q <= blink;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: expected per-cycle display words are queued
// per frame from the digit/blank/dot/blink settings and compared as the scan runs.
module tb_ssd_scan_ctrl;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp_on = 4'h0, blank = 4'h0, blink = 4'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_tick;

    logic [31:0] digits8 = 32'h76543210;
    logic [7:0]  zero8 = 8'h0;
    logic [7:0]  an8;
    logic [6:0]  seg8;
    logic        dp8, ft8;

    logic [11:0] digits3 = 12'h210;
    logic [2:0]  zero3 = 3'h0;
    logic [7:0]  an3;
    logic [6:0]  seg3;
    logic        dp3, ft3;

    int checks = 0;
    int errors = 0;
    int frm = 0;

    logic [16:0] sbq[$];
    logic [14:0] q8[$];
    logic [7:0]  q3[$];

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .BLINK_FRAMES(2)) dut (
        .board_clk(clk), .Reset(Reset), .digits(digits), .dp_on(dp_on), .blank(blank),
        .blink(blink), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick));

    ssd_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4), .GUARD(0), .BLINK_FRAMES(1)) dut8 (
        .board_clk(clk), .Reset(Reset), .digits(digits8), .dp_on(zero8), .blank(zero8),
        .blink(zero8), .an(an8), .seg(seg8), .dp(dp8), .frame_tick(ft8));

    ssd_scan_ctrl #(.NUM_DIGITS(3), .SCAN_DIV(4), .GUARD(0), .BLINK_FRAMES(1)) dut3 (
        .board_clk(clk), .Reset(Reset), .digits(digits3), .dp_on(zero3), .blank(zero3),
        .blink(zero3), .an(an3), .seg(seg3), .dp(dp3), .frame_tick(ft3));

    function automatic logic [6:0] hexseg(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return tbl[v];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One frame of the 4-digit instance: 32 words {frame_tick, an, seg, dp}.
    task automatic push_frame(input logic [15:0] dg, input logic [3:0] bl,
                              input logic [3:0] dpo, input logic [3:0] blk);
        logic       bph, dark;
        logic [7:0] a;
        logic [6:0] s;
        logic       d, ft;
        bph = ((frm >> 1) & 1) != 0;
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 8; p++) begin
                dark = (p < 2) || bl[k] || (blk[k] && bph);
                a    = 8'hFF;
                if (!dark) a[k] = 1'b0;
                s    = dark ? 7'h7F : hexseg(dg[4*k +: 4]);
                d    = dark ? 1'b1 : ~dpo[k];
                ft   = (k == 3) && (p == 7);
                sbq.push_back({ft, a, s, d});
            end
        end
        frm++;
    endtask

    task automatic run_cycles(input int n);
        logic [16:0] e;
        logic [14:0] e8;
        logic [7:0]  e3;
        repeat (n) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("frame_tick", {31'd0, frame_tick}, {31'd0, e[16]});
                chk("an", {24'd0, an}, {24'd0, e[15:8]});
                chk("seg", {25'd0, seg}, {25'd0, e[7:1]});
                chk("dp", {31'd0, dp}, {31'd0, e[0]});
            end
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                chk("an8", {24'd0, an8}, {24'd0, e8[14:7]});
                chk("seg8", {25'd0, seg8}, {25'd0, e8[6:0]});
            end
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                chk("an3", {24'd0, an3}, {24'd0, e3});
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"}, {24'd0, an}, 32'h0000_00FF);
        chk({tag, "_seg"}, {25'd0, seg}, 32'h0000_007F);
        chk({tag, "_dp"}, {31'd0, dp}, 32'd1);
        chk({tag, "_ft"}, {31'd0, frame_tick}, 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        int k;
        digits = 16'h1A3F;
        repeat (3) @(negedge clk);
        chk_reset("rst_hold");

        // Release; first frame shows zero shadows on all digits.
        Reset = 1'b0;
        push_frame(16'h0000, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 64; i++) begin
            k = (i / 4) % 8;
            a = 8'hFF;
            a[k] = 1'b0;
            q8.push_back({a, (i < 32) ? hexseg(4'h0) : hexseg(4'(k))});
        end
        for (int i = 0; i < 36; i++) begin
            k = (i / 4) % 3;
            a = 8'hFF;
            a[k] = 1'b0;
            q3.push_back(a);
        end
        run_cycles(32);

        push_frame(16'h1A3F, 4'h0, 4'h0, 4'h0);
        run_cycles(32);

        // Mid-frame change must not appear until the next capture.
        push_frame(16'h1A3F, 4'h0, 4'h0, 4'h0);
        run_cycles(13);
        digits = 16'h0000;
        run_cycles(19);

        push_frame(16'h0000, 4'h0, 4'h0, 4'h0);
        run_cycles(10);
        digits = 16'h1A3F;
        blank  = 4'b0100;
        dp_on  = 4'b0001;
        run_cycles(22);

        push_frame(16'h1A3F, 4'b0100, 4'b0001, 4'h0);
        run_cycles(10);
        blank = 4'h0;
        dp_on = 4'h0;
        blink = 4'b0010;
        run_cycles(22);

        for (int f = 0; f < 4; f++) begin
            push_frame(16'h1A3F, 4'h0, 4'h0, 4'b0010);
            run_cycles(32);
        end

        // Asynchronous reset while digit 3 is lit.
        push_frame(16'h1A3F, 4'h0, 4'h0, 4'b0010);
        run_cycles(28);
        chk("pre_rst_an", {24'd0, an}, 32'h0000_00F7);
        Reset = 1'b1;
        #1;
        chk_reset("rst_async");
        sbq.delete();
        repeat (2) @(negedge clk);
        chk_reset("rst_mid");

        Reset = 1'b0;
        frm = 0;
        push_frame(16'h0000, 4'h0, 4'h0, 4'h0);
        run_cycles(32);
        push_frame(16'h1A3F, 4'h0, 4'h0, 4'b0010);
        run_cycles(32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
